regfile_mp: RTL and testbench

Multi-ported, parametrised register file for the CPU datapath, generalising the two-read/one-write file to N read ports and M write ports. Adds a hardwired-zero register option, same-cycle write-to-read bypass, and a post-reset clear sequencer that zeroes every entry and reports `ready`. Sits between decode (read ports) and writeback (write ports); decode must stall while `ready` is low.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clr_seq.sv | 37 +++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-ported register file.
// Covers the clear/run sequencer state and the port-slice index arithmetic.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } seq_state_e;

   // Low bit of port `port` inside a flat bus of `width`-bit fields.
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks every entry once, issuing zero-writes,
// then raises ready and stays in RUN until the next reset.
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_SIZE = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 ready,
   output logic                 clr_en,
   output logic [ADDR_SIZE-1:0] clr_addr
);

   seq_state_e           state;
   logic [ADDR_SIZE-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         count <= '0;
         ready <= 1'b0;
      end else if (state == CLEAR) begin
         count <= count + 1'b1;
         if (count == '1) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end
   end

   assign clr_en   = (state == CLEAR);
   assign clr_addr = count;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-read / M-write register file with optional hardwired-zero
// entry, same-cycle write-to-read bypass and a post-reset clear sequence.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32,
   parameter int R_PORTS   = 2,
   parameter int W_PORTS   = 2,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [R_PORTS*ADDR_SIZE-1:0] r_addr,
   output logic [R_PORTS*WORD_SIZE-1:0] r_data,
   input  logic [W_PORTS-1:0]           w_en,
   input  logic [W_PORTS*ADDR_SIZE-1:0] w_addr,
   input  logic [W_PORTS*WORD_SIZE-1:0] w_data,
   output logic                         ready
);

   localparam int DEPTH = 2 ** ADDR_SIZE;

   logic [WORD_SIZE-1:0] mem [DEPTH];

   logic                 clr_en;
   logic [ADDR_SIZE-1:0] clr_addr;

   regfile_clr_seq #(
      .ADDR_SIZE (ADDR_SIZE)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   logic [ADDR_SIZE-1:0] wa [W_PORTS];
   logic [WORD_SIZE-1:0] wd [W_PORTS];
   logic [W_PORTS-1:0]   we;

   // User writes only count in RUN, and never reach the hardwired-zero entry.
   for (genvar p = 0; p < W_PORTS; p++) begin : g_wr
      logic zero_hit;
      assign wa[p]    = w_addr[slice_lo(p, ADDR_SIZE) +: ADDR_SIZE];
      assign wd[p]    = w_data[slice_lo(p, WORD_SIZE) +: WORD_SIZE];
      assign zero_hit = (ZERO_REG != 0) && (wa[p] == '0);
      assign we[p]    = w_en[p] & ready & ~zero_hit;
   end

   // NOTE: storage has no reset branch; the clear sequencer zeroes it, which
   // keeps the array mappable onto plain flops or RAM without a reset tree.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_addr] <= '0;
      end else begin
         // Higher-numbered ports are scheduled last, so they win collisions.
         for (int p = 0; p < W_PORTS; p++) begin
            if (we[p]) mem[wa[p]] <= wd[p];
         end
      end
   end

   for (genvar p = 0; p < R_PORTS; p++) begin : g_rd
      logic [ADDR_SIZE-1:0] ra;
      logic [WORD_SIZE-1:0] rd;

      assign ra = r_addr[slice_lo(p, ADDR_SIZE) +: ADDR_SIZE];

      // NOTE: rd gets a default before any condition so no latch is inferred.
      always_comb begin
         rd = mem[ra];
         if (BYPASS != 0) begin
            for (int q = 0; q < W_PORTS; q++) begin
               if (we[q] && (wa[q] == ra)) rd = wd[q];
            end
         end
         if (!ready || ((ZERO_REG != 0) && (ra == '0))) rd = '0;
      end

      assign r_data[slice_lo(p, WORD_SIZE) +: WORD_SIZE] = rd;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass+zero-reg, plain) on shared
// stimulus, checked every cycle against an array-based reference model.
module tb_regfile_mp;

   localparam int AS    = 5;
   localparam int WS    = 32;
   localparam int NR    = 2;
   localparam int NW    = 2;
   localparam int DEPTH = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*AS-1:0]  r_addr;
   logic [NW-1:0]     w_en;
   logic [NW*AS-1:0]  w_addr;
   logic [NW*WS-1:0]  w_data;
   logic [NR*WS-1:0]  r_data_a, r_data_b;
   logic              ready_a, ready_b;

   int checks   = 0;
   int failures = 0;

   logic [WS-1:0] mem_a [DEPTH];
   logic [WS-1:0] mem_b [DEPTH];
   int            run_cnt = 0;

   regfile_mp #(
      .ADDR_SIZE (AS), .WORD_SIZE (WS), .R_PORTS (NR), .W_PORTS (NW),
      .ZERO_REG  (1),  .BYPASS    (1)
   ) dut_a (
      .clk (clk), .rst (rst), .r_addr (r_addr), .r_data (r_data_a),
      .w_en (w_en), .w_addr (w_addr), .w_data (w_data), .ready (ready_a)
   );

   regfile_mp #(
      .ADDR_SIZE (AS), .WORD_SIZE (WS), .R_PORTS (NR), .W_PORTS (NW),
      .ZERO_REG  (0),  .BYPASS    (0)
   ) dut_b (
      .clk (clk), .rst (rst), .r_addr (r_addr), .r_data (r_data_b),
      .w_en (w_en), .w_addr (w_addr), .w_data (w_data), .ready (ready_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WS-1:0] exp_rd(input bit zr, input bit bp, input int p);
      logic [AS-1:0] ra;
      ra = r_addr[p*AS +: AS];
      if (run_cnt < DEPTH) return '0;
      if (zr && ra == 0) return '0;
      if (bp) begin
         if (w_en[1] && w_addr[2*AS-1:AS] == ra) return w_data[2*WS-1:WS];
         if (w_en[0] && w_addr[AS-1:0] == ra) return w_data[WS-1:0];
      end
      return zr ? mem_a[ra] : mem_b[ra];
   endfunction

   task automatic model_edge();
      logic [AS-1:0] a0, a1;
      a0 = w_addr[AS-1:0];
      a1 = w_addr[2*AS-1:AS];
      if (rst) begin
         run_cnt = 0;
      end else if (run_cnt >= DEPTH) begin
         if (w_en[1]) begin
            if (a1 != 0) mem_a[a1] = w_data[2*WS-1:WS];
            mem_b[a1] = w_data[2*WS-1:WS];
         end
         if (w_en[0] && !(w_en[1] && a1 == a0)) begin
            if (a0 != 0) mem_a[a0] = w_data[WS-1:0];
            mem_b[a0] = w_data[WS-1:0];
         end
      end else begin
         run_cnt++;
         if (run_cnt == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_a[i] = '0;
               mem_b[i] = '0;
            end
         end
      end
   endtask

   // Inputs are applied at the falling edge; outputs are checked just after,
   // then the model advances on the rising edge.
   task automatic step();
      #1;
      check("ready_a", {31'b0, ready_a}, {31'b0, run_cnt >= DEPTH});
      check("ready_b", {31'b0, ready_b}, {31'b0, run_cnt >= DEPTH});
      for (int p = 0; p < NR; p++) begin
         check($sformatf("rd_a%0d@%0d", p, r_addr[p*AS +: AS]), r_data_a[p*WS +: WS], exp_rd(1'b1, 1'b1, p));
         check($sformatf("rd_b%0d@%0d", p, r_addr[p*AS +: AS]), r_data_b[p*WS +: WS], exp_rd(1'b0, 1'b0, p));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (v) run_cnt = 0;
   endtask

   task automatic set_in(input logic [1:0] en, input int a0, input int a1,
                         input logic [WS-1:0] d0, input logic [WS-1:0] d1,
                         input int r0, input int r1);
      w_en   = en;
      w_addr = {a1[AS-1:0], a0[AS-1:0]};
      w_data = {d1, d0};
      r_addr = {r1[AS-1:0], r0[AS-1:0]};
   endtask

   task automatic idle_read(input int n);
      for (int i = 0; i < n; i++) begin
         set_in(2'b00, 0, 0, '0, '0, $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
         step();
      end
   endtask

   initial begin
      set_rst(1'b1);
      set_in(2'b00, 0, 0, '0, '0, 0, 0);
      repeat (2) @(negedge clk);
      step();

      // Clear after reset, with writes to addr 3 attempted throughout.
      set_rst(1'b0);
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (i < DEPTH) set_in(2'b11, 3, 3, 32'hAAAAAAAA, 32'hAAAAAAAA, 3, i % DEPTH);
         else           set_in(2'b00, 0, 0, '0, '0, 3, i % DEPTH);
         step();
      end

      // Port 0 write with same-cycle and next-cycle reads.
      set_in(2'b01, 5, 0, 32'hDEADBEEF, '0, 5, 5);
      step();
      set_in(2'b00, 0, 0, '0, '0, 4, 5);
      step();

      // Collision on addr 7: port 1 wins in storage and on the bypass.
      set_in(2'b11, 7, 7, 32'h11111111, 32'h22222222, 7, 7);
      step();
      set_in(2'b00, 0, 0, '0, '0, 7, 5);
      step();

      // Address 0 write: dropped by the zero-reg instance only.
      set_in(2'b10, 0, 0, '0, 32'hFFFFFFFF, 0, 0);
      step();
      set_in(2'b00, 0, 0, '0, '0, 0, 3);
      step();

      // Randomised traffic on a narrow address range to force collisions.
      for (int i = 0; i < 400; i++) begin
         set_in(2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom, $urandom,
                $urandom_range(0, 7), $urandom_range(0, 7));
         step();
      end

      // Reset mid-clear at counter 10, then a full clear.
      set_rst(1'b1);
      idle_read(2);
      set_rst(1'b0);
      idle_read(10);
      set_rst(1'b1);
      idle_read(1);
      set_rst(1'b0);
      idle_read(DEPTH + 2);

      // Fill every entry, reset in RUN, and confirm the re-clear.
      for (int i = 0; i < DEPTH / 2; i++) begin
         set_in(2'b11, 2*i, 2*i + 1, $urandom, $urandom, 2*i, 2*i + 1);
         step();
      end
      for (int i = 0; i < DEPTH / 2; i++) begin
         set_in(2'b00, 0, 0, '0, '0, 2*i, 2*i + 1);
         step();
      end
      set_rst(1'b1);
      set_in(2'b00, 0, 0, '0, '0, 9, 10);
      step();
      set_rst(1'b0);
      idle_read(DEPTH + 1);
      for (int i = 0; i < DEPTH / 2; i++) begin
         set_in(2'b00, 0, 0, '0, '0, 2*i, 2*i + 1);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
